// File: rtl/codec_cfg_pkg.sv
// Shared types, codec register addresses and the default SSM2603 start-up table
// for the codec configuration sequencer.
package codec_cfg_pkg;

  typedef enum logic [3:0] {
    S_WAIT_PWR,
    S_LOAD,
    S_EXEC,
    S_WAIT_DONE,
    S_CHECK,
    S_DELAY,
    S_DONE,
    S_ERROR,
    S_USER_ACK
  } state_t;

  localparam logic [6:0] R0  = 7'd0;
  localparam logic [6:0] R1  = 7'd1;
  localparam logic [6:0] R2  = 7'd2;
  localparam logic [6:0] R3  = 7'd3;
  localparam logic [6:0] R4  = 7'd4;
  localparam logic [6:0] R5  = 7'd5;
  localparam logic [6:0] R6  = 7'd6;
  localparam logic [6:0] R7  = 7'd7;
  localparam logic [6:0] R8  = 7'd8;
  localparam logic [6:0] R9  = 7'd9;
  localparam logic [6:0] R10 = 7'd10;
  localparam logic [6:0] R11 = 7'd11;
  localparam logic [6:0] R12 = 7'd12;
  localparam logic [6:0] R13 = 7'd13;
  localparam logic [6:0] R14 = 7'd14;
  localparam logic [6:0] R15 = 7'd15;

  localparam logic [4:0] USER_ERR_INDEX = 5'd31;

  function automatic logic [1:0] iwl_from_wl(input int wl);
    case (wl)
      16:      return 2'b00;
      20:      return 2'b01;
      24:      return 2'b10;
      32:      return 2'b11;
      default: return 2'b00;
    endcase
  endfunction

  // Entry layout {addr[6:0], data[8:0]} equals {i2c_addr, i2c_data_w} on the bus.
  function automatic logic [15:0] table_entry(input int idx, input int wl);
    logic [8:0] r7_data;
    r7_data = 9'h002 | {5'd0, iwl_from_wl(wl), 2'b00};
    case (idx)
      0:       return {R15, 9'h000};
      1:       return {R0,  9'h017};
      2:       return {R1,  9'h017};
      3:       return {R2,  9'h179};
      4:       return {R3,  9'h179};
      5:       return {R4,  9'h010};
      6:       return {R5,  9'h000};
      7:       return {R6,  9'h010};
      8:       return {R7,  r7_data};
      9:       return {R8,  9'h000};
      10:      return {R9,  9'h001};
      11:      return {R6,  9'h000};
      default: return {R9,  9'h001};
    endcase
  endfunction

endpackage

// File: rtl/codec_cfg_rom.sv
// Combinational lookup of the codec start-up table: index -> {addr[6:0], data[8:0]}.
module codec_cfg_rom
  import codec_cfg_pkg::*;
#(
  parameter int WL       = 16,
  parameter int NUM_REGS = 12
) (
  input  logic [4:0]  index,
  output logic [15:0] entry
);

  always_comb begin
    entry = '0;
    if (32'(index) < 32'(NUM_REGS)) entry = table_entry(int'(index), WL);
  end

endmodule

// File: rtl/codec_cfg_seq.sv
// Codec configuration sequencer: walks the start-up table through an I2C byte-write
// driver with power-up delays, NACK/timeout retry and error reporting.
// Optional runtime single-register write port enabled by CODEC_CFG_USER_WR_EN.
module codec_cfg_seq
  import codec_cfg_pkg::*;
#(
  parameter int NUM_REGS     = 12,
  parameter int WL           = 16,
  parameter int MAX_RETRY    = 3,
  parameter int STARTUP_CYC  = 1024,
  parameter int ACTIVATE_DLY = 4096,
  parameter int TIMEOUT_CYC  = 65535
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       start,
  output logic       i2c_exec,
  output logic [7:0] i2c_addr,
  output logic [7:0] i2c_data_w,
  input  logic       i2c_done,
  input  logic       i2c_ack,
  output logic       cfg_busy,
  output logic       cfg_done,
  output logic       cfg_err,
  output logic [4:0] err_index,
  input  logic       user_wr_req,
  input  logic [6:0] user_wr_addr,
  input  logic [8:0] user_wr_data,
  output logic       user_wr_ack
);

  state_t      state, state_n;
  logic [31:0] cnt, cnt_n;
  logic [5:0]  idx, idx_n;
  logic [2:0]  retry, retry_n;
  logic [15:0] word, word_n;
  logic        done_f, done_n;
  logic        err_f, err_n;
  logic [4:0]  eidx, eidx_n;
  logic        user, user_n;
  logic        ret_err, ret_err_n;
  logic        user_cap;
  logic [15:0] user_word;
  logic [15:0] rom_entry;
  logic        user_go;
  logic [15:0] user_in;

`ifdef CODEC_CFG_USER_WR_EN
  assign user_go     = user_wr_req;
  assign user_in     = {user_wr_addr, user_wr_data};
  assign user_wr_ack = (state == S_USER_ACK);
`else
  logic unused_user;
  assign user_go     = 1'b0;
  assign user_in     = '0;
  assign user_wr_ack = 1'b0;
  assign unused_user = ^{user_wr_req, user_wr_addr, user_wr_data};
`endif

  codec_cfg_rom #(
    .WL       (WL),
    .NUM_REGS (NUM_REGS)
  ) u_rom (
    .index (idx[4:0]),
    .entry (rom_entry)
  );

  assign i2c_exec   = (state == S_EXEC);
  assign i2c_addr   = word[15:8];
  assign i2c_data_w = word[7:0];
  assign cfg_done   = done_f;
  assign cfg_err    = err_f;
  assign err_index  = eidx;

  always_comb begin
    state_n   = state;
    cnt_n     = cnt;
    idx_n     = idx;
    retry_n   = retry;
    word_n    = word;
    done_n    = done_f;
    err_n     = err_f;
    eidx_n    = eidx;
    user_n    = user;
    ret_err_n = ret_err;
    user_cap  = 1'b0;
    case (state)
      S_WAIT_PWR: begin
        if (cnt + 32'd1 >= 32'(STARTUP_CYC)) begin
          state_n = S_LOAD;
          cnt_n   = '0;
          idx_n   = '0;
          retry_n = '0;
        end else begin
          cnt_n = cnt + 32'd1;
        end
      end
      S_LOAD: begin
        word_n  = user ? user_word : rom_entry;
        state_n = S_EXEC;
      end
      S_EXEC: begin
        cnt_n   = '0;
        state_n = S_WAIT_DONE;
      end
      S_WAIT_DONE: begin
        cnt_n = cnt + 32'd1;
        // A completion in the same cycle as the timeout still counts as a response.
        if (i2c_done && !i2c_ack) begin
          retry_n = '0;
          if (user) begin
            state_n = S_USER_ACK;
          end else begin
            idx_n   = idx + 6'd1;
            state_n = S_CHECK;
          end
        end else if (i2c_done || (cnt + 32'd1 >= 32'(TIMEOUT_CYC))) begin
          if (32'(retry) < 32'(MAX_RETRY)) begin
            retry_n = retry + 3'd1;
            state_n = S_LOAD;
          end else begin
            state_n = S_ERROR;
            err_n   = 1'b1;
            done_n  = 1'b0;
            eidx_n  = user ? USER_ERR_INDEX : idx[4:0];
            user_n  = 1'b0;
          end
        end
      end
      S_CHECK: begin
        if (idx == 6'(NUM_REGS)) begin
          state_n = S_DONE;
          done_n  = 1'b1;
        end else if ((idx == 6'(NUM_REGS - 1)) && (ACTIVATE_DLY > 0)) begin
          state_n = S_DELAY;
          cnt_n   = '0;
        end else begin
          state_n = S_LOAD;
        end
      end
      S_DELAY: begin
        if (cnt + 32'd1 >= 32'(ACTIVATE_DLY)) begin
          state_n = S_LOAD;
          cnt_n   = '0;
        end else begin
          cnt_n = cnt + 32'd1;
        end
      end
      S_DONE, S_ERROR: begin
        if (start) begin
          state_n = S_LOAD;
          done_n  = 1'b0;
          err_n   = 1'b0;
          eidx_n  = '0;
          idx_n   = '0;
          retry_n = '0;
          user_n  = 1'b0;
        end else if (user_go) begin
          state_n   = S_LOAD;
          retry_n   = '0;
          user_n    = 1'b1;
          user_cap  = 1'b1;
          ret_err_n = (state == S_ERROR);
        end
      end
      S_USER_ACK: begin
        user_n  = 1'b0;
        state_n = ret_err ? S_ERROR : S_DONE;
      end
      default: state_n = S_WAIT_PWR;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state    <= S_WAIT_PWR;
      cnt      <= '0;
      idx      <= '0;
      retry    <= '0;
      word     <= '0;
      done_f   <= 1'b0;
      err_f    <= 1'b0;
      eidx     <= '0;
      user     <= 1'b0;
      ret_err  <= 1'b0;
      cfg_busy <= 1'b0;
    end else begin
      state    <= state_n;
      cnt      <= cnt_n;
      idx      <= idx_n;
      retry    <= retry_n;
      word     <= word_n;
      done_f   <= done_n;
      err_f    <= err_n;
      eidx     <= eidx_n;
      user     <= user_n;
      ret_err  <= ret_err_n;
      cfg_busy <= !(state_n inside {S_DONE, S_ERROR});
    end
  end

  // Captured request payload is pure data, qualified by the user flag.
  always_ff @(posedge clk) begin
    if (user_cap) user_word <= user_in;
  end

endmodule

// File: tb/tb_codec_cfg_seq.sv
// Directed self-checking bench for codec_cfg_seq: three instances with different
// parameter sets, each served by a scripted I2C driver model.
module tb_codec_cfg_seq;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_vec  = 0;
  int n_miss = 0;

  logic [15:0] exp_tbl [12] = '{16'h1E00, 16'h0017, 16'h0217, 16'h0579, 16'h0779, 16'h0810,
                                16'h0A00, 16'h0C10, 16'h0E02, 16'h1000, 16'h1201, 16'h0C00};

  // ---------------- instance A: default parameters ----------------
  logic       rst_a = 1'b0, start_a = 1'b0, exec_a, done_a, ack_a, busy_a, cdone_a, err_a, uack_a;
  logic [7:0] addr_a, dw_a;
  logic [4:0] eidx_a;
  logic       ureq_a = 1'b0;
  logic [6:0] uaddr_a = '0;
  logic [8:0] udata_a = '0;

  codec_cfg_seq dut_a (
    .clk(clk), .reset(rst_a), .start(start_a), .i2c_exec(exec_a), .i2c_addr(addr_a),
    .i2c_data_w(dw_a), .i2c_done(done_a), .i2c_ack(ack_a), .cfg_busy(busy_a),
    .cfg_done(cdone_a), .cfg_err(err_a), .err_index(eidx_a), .user_wr_req(ureq_a),
    .user_wr_addr(uaddr_a), .user_wr_data(udata_a), .user_wr_ack(uack_a)
  );

  // ---------------- instance B: WL=24, short timeout ----------------
  logic       rst_b = 1'b0, start_b = 1'b0, exec_b, done_b, ack_b, busy_b, cdone_b, err_b, uack_b;
  logic [7:0] addr_b, dw_b;
  logic [4:0] eidx_b;
  logic       ureq_b = 1'b0;
  logic [6:0] uaddr_b = '0;
  logic [8:0] udata_b = '0;

  codec_cfg_seq #(.WL(24), .TIMEOUT_CYC(100), .STARTUP_CYC(16), .ACTIVATE_DLY(8)) dut_b (
    .clk(clk), .reset(rst_b), .start(start_b), .i2c_exec(exec_b), .i2c_addr(addr_b),
    .i2c_data_w(dw_b), .i2c_done(done_b), .i2c_ack(ack_b), .cfg_busy(busy_b),
    .cfg_done(cdone_b), .cfg_err(err_b), .err_index(eidx_b), .user_wr_req(ureq_b),
    .user_wr_addr(uaddr_b), .user_wr_data(udata_b), .user_wr_ack(uack_b)
  );

  // ---------------- instance C: WL=18, 9 entries ----------------
  logic       rst_c = 1'b0, start_c = 1'b0, exec_c, done_c, ack_c, busy_c, cdone_c, err_c, uack_c;
  logic [7:0] addr_c, dw_c;
  logic [4:0] eidx_c;

  codec_cfg_seq #(.WL(18), .NUM_REGS(9), .STARTUP_CYC(16), .ACTIVATE_DLY(8)) dut_c (
    .clk(clk), .reset(rst_c), .start(start_c), .i2c_exec(exec_c), .i2c_addr(addr_c),
    .i2c_data_w(dw_c), .i2c_done(done_c), .i2c_ack(ack_c), .cfg_busy(busy_c),
    .cfg_done(cdone_c), .cfg_err(err_c), .err_index(eidx_c), .user_wr_req(1'b0),
    .user_wr_addr(7'd0), .user_wr_data(9'd0), .user_wr_ack(uack_c)
  );

  // ---------------- driver models ----------------
  logic [15:0] log_a[$], log_b[$], log_c[$];
  int          cyc_a[$], cyc_b[$];
  logic [15:0] nack_key_a = 16'hFFFF;
  int          nack_left_a = 0;  // -1 = NACK forever
  bit          silent_b = 1'b0;
  logic [15:0] w_a, w_b;

  initial begin
    done_a = 1'b0; ack_a = 1'b0;
    forever begin
      @(posedge clk); #1;
      if (exec_a) begin
        w_a = {addr_a, dw_a};
        log_a.push_back(w_a);
        cyc_a.push_back(cyc);
        repeat (49) @(posedge clk);
        #1;
        ack_a = 1'b0;
        if (w_a == nack_key_a && nack_left_a != 0) begin
          ack_a = 1'b1;
          if (nack_left_a > 0) nack_left_a--;
        end
        done_a = 1'b1;
        @(posedge clk); #1;
        done_a = 1'b0; ack_a = 1'b0;
      end
    end
  end

  initial begin
    done_b = 1'b0; ack_b = 1'b0;
    forever begin
      @(posedge clk); #1;
      if (exec_b) begin
        w_b = {addr_b, dw_b};
        log_b.push_back(w_b);
        cyc_b.push_back(cyc);
        if (!silent_b) begin
          repeat (2) @(posedge clk);
          #1 done_b = 1'b1;
          @(posedge clk); #1 done_b = 1'b0;
        end
      end
    end
  end

  initial begin
    done_c = 1'b0; ack_c = 1'b0;
    forever begin
      @(posedge clk); #1;
      if (exec_c) begin
        log_c.push_back({addr_c, dw_c});
        @(posedge clk); #1 done_c = 1'b1;
        @(posedge clk); #1 done_c = 1'b0;
      end
    end
  end

  // ---------------- tests ----------------
  int rel_a;

  task automatic pulse_start_a();
    @(posedge clk); #1 start_a = 1'b1;
    @(posedge clk); #1 start_a = 1'b0;
  endtask

  task automatic wait_done_a(input int budget, input string tag);
    bit ok = 1'b0;
    for (int k = 0; k < budget; k++) begin
      @(posedge clk); #1;
      if (cdone_a) begin ok = 1'b1; break; end
    end
    n_vec++;
    if (!ok) begin n_miss++; $display("FAIL %s_timeout: cfg_done=%0b after %0d cycles, want 1", tag, cdone_a, budget); end
  endtask

  task automatic test_reset();
    repeat (3) @(posedge clk);
    #1;
    n_vec++;
    if ({exec_a, addr_a, dw_a, busy_a, cdone_a, err_a, eidx_a, uack_a} !== '0) begin
      n_miss++;
      $display("FAIL reset_outputs: exec=%0b addr=%h data=%h busy=%0b done=%0b err=%0b eidx=%0d uack=%0b, want all 0",
               exec_a, addr_a, dw_a, busy_a, cdone_a, err_a, eidx_a, uack_a);
    end
    rst_a = 1'b1;
    rel_a = cyc;
    @(posedge clk); #1;
    n_vec++;
    if (busy_a !== 1'b1) begin n_miss++; $display("FAIL busy_after_release: got %0b want 1", busy_a); end
  endtask

  task automatic test_full_run();
    wait_done_a(15000, "full_run");
    n_vec++;
    if (log_a.size() != 12) begin n_miss++; $display("FAIL full_run_count: got %0d writes want 12", log_a.size()); end
    for (int i = 0; i < 12 && i < log_a.size(); i++) begin
      n_vec++;
      if (log_a[i] !== exp_tbl[i]) begin
        n_miss++; $display("FAIL full_run_entry%0d: got %h want %h", i, log_a[i], exp_tbl[i]);
      end
    end
    if (cyc_a.size() == 12) begin
      n_vec++;
      if (cyc_a[0] - rel_a < 1024 || cyc_a[0] - rel_a > 1030) begin
        n_miss++; $display("FAIL startup_delay: first exec %0d cycles after release, want 1024..1030", cyc_a[0] - rel_a);
      end
      n_vec++;
      if (cyc_a[11] - cyc_a[10] < 4096) begin
        n_miss++; $display("FAIL activate_gap: got %0d cycles want >=4096", cyc_a[11] - cyc_a[10]);
      end
    end
    n_vec++;
    if ({busy_a, err_a} !== 2'b00) begin n_miss++; $display("FAIL full_run_flags: busy=%0b err=%0b want 0 0", busy_a, err_a); end
  endtask

  task automatic test_nack_retry();
    log_a.delete(); cyc_a.delete();
    nack_key_a = 16'h0579; nack_left_a = 2;
    pulse_start_a();
    n_vec++;
    if (cdone_a !== 1'b0) begin n_miss++; $display("FAIL start_clears_done: got %0b want 0", cdone_a); end
    wait_done_a(15000, "nack_retry");
    n_vec++;
    if (log_a.size() != 14) begin n_miss++; $display("FAIL nack_retry_count: got %0d want 14", log_a.size()); end
    if (log_a.size() == 14) begin
      n_vec++;
      if (log_a[3] !== 16'h0579 || log_a[4] !== 16'h0579 || log_a[5] !== 16'h0579 || log_a[6] !== exp_tbl[4]) begin
        n_miss++; $display("FAIL nack_retry_seq: got %h %h %h %h want 0579 0579 0579 %h",
                           log_a[3], log_a[4], log_a[5], log_a[6], exp_tbl[4]);
      end
    end
    n_vec++;
    if (err_a !== 1'b0) begin n_miss++; $display("FAIL nack_retry_err: got %0b want 0", err_a); end
  endtask

  task automatic test_nack_fail();
    bit ok = 1'b0;
    log_a.delete(); cyc_a.delete();
    nack_key_a = 16'h0810; nack_left_a = -1;
    pulse_start_a();
    for (int k = 0; k < 5000; k++) begin
      @(posedge clk); #1;
      if (err_a) begin ok = 1'b1; break; end
    end
    n_vec++;
    if (!ok) begin n_miss++; $display("FAIL nack_fail_timeout: cfg_err=%0b want 1", err_a); end
    n_vec++;
    if (eidx_a !== 5'd5 || busy_a !== 1'b0 || cdone_a !== 1'b0) begin
      n_miss++; $display("FAIL nack_fail_state: eidx=%0d busy=%0b done=%0b want 5 0 0", eidx_a, busy_a, cdone_a);
    end
    repeat (200) @(posedge clk);
    #1;
    n_vec++;
    if (log_a.size() != 9) begin n_miss++; $display("FAIL nack_fail_attempts: got %0d writes want 9", log_a.size()); end
    if (log_a.size() == 9) begin
      n_vec++;
      if (log_a[5] !== 16'h0810 || log_a[8] !== 16'h0810) begin
        n_miss++; $display("FAIL nack_fail_entry: got %h %h want 0810 0810", log_a[5], log_a[8]);
      end
    end
  endtask

  task automatic test_restart();
    log_a.delete(); cyc_a.delete();
    nack_left_a = 0;
    pulse_start_a();
    n_vec++;
    if (err_a !== 1'b0) begin n_miss++; $display("FAIL restart_clears_err: got %0b want 0", err_a); end
    wait_done_a(15000, "restart");
    n_vec++;
    if (log_a.size() != 12 || log_a[0] !== 16'h1E00) begin
      n_miss++; $display("FAIL restart_run: got %0d writes first %h want 12 writes first 1e00",
                         log_a.size(), (log_a.size() > 0) ? log_a[0] : 16'h0);
    end
  endtask

  task automatic test_reset_mid();
    bit ok = 1'b0;
    log_a.delete(); cyc_a.delete();
    pulse_start_a();
    for (int k = 0; k < 2000; k++) begin
      @(posedge clk); #1;
      if (log_a.size() >= 7) begin ok = 1'b1; break; end
    end
    n_vec++;
    if (!ok) begin n_miss++; $display("FAIL reset_mid_reach: got %0d writes want 7", log_a.size()); end
    @(negedge clk);
    rst_a = 1'b0;
    #1;
    n_vec++;
    if ({exec_a, addr_a, dw_a, busy_a, cdone_a, err_a} !== '0) begin
      n_miss++; $display("FAIL reset_mid_outputs: exec=%0b addr=%h data=%h busy=%0b done=%0b err=%0b want all 0",
                         exec_a, addr_a, dw_a, busy_a, cdone_a, err_a);
    end
    repeat (3) @(posedge clk);
    #1 rst_a = 1'b1;
    rel_a = cyc;
    log_a.delete(); cyc_a.delete();
    ok = 1'b0;
    for (int k = 0; k < 2000; k++) begin
      @(posedge clk); #1;
      if (log_a.size() >= 1) begin ok = 1'b1; break; end
    end
    n_vec++;
    if (!ok || cyc_a[0] - rel_a < 1024 || cyc_a[0] - rel_a > 1030 || log_a[0] !== 16'h1E00) begin
      n_miss++; $display("FAIL reset_mid_restart: first write %h at %0d cycles, want 1e00 at 1024..1030",
                         ok ? log_a[0] : 16'h0, ok ? cyc_a[0] - rel_a : -1);
    end
    wait_done_a(15000, "reset_mid_run");
  endtask

  task automatic test_wl24_timeout();
    bit ok = 1'b0;
    rst_b = 1'b1;
    for (int k = 0; k < 2000; k++) begin
      @(posedge clk); #1;
      if (cdone_b) begin ok = 1'b1; break; end
    end
    n_vec++;
    if (!ok || log_b.size() != 12 || log_b[8] !== 16'h0E0A) begin
      n_miss++; $display("FAIL wl24_r7: done=%0b writes=%0d r7=%h want 1 12 0e0a",
                         cdone_b, log_b.size(), (log_b.size() > 8) ? log_b[8] : 16'h0);
    end
    log_b.delete(); cyc_b.delete();
    silent_b = 1'b1;
    @(posedge clk); #1 start_b = 1'b1;
    @(posedge clk); #1 start_b = 1'b0;
    ok = 1'b0;
    for (int k = 0; k < 2000; k++) begin
      @(posedge clk); #1;
      if (err_b) begin ok = 1'b1; break; end
    end
    n_vec++;
    if (!ok || eidx_b !== 5'd0 || busy_b !== 1'b0) begin
      n_miss++; $display("FAIL timeout_err: err=%0b eidx=%0d busy=%0b want 1 0 0", err_b, eidx_b, busy_b);
    end
    n_vec++;
    if (log_b.size() != 4 || log_b[0] !== 16'h1E00 || log_b[3] !== 16'h1E00) begin
      n_miss++; $display("FAIL timeout_attempts: got %0d writes want 4 of 1e00", log_b.size());
    end
    if (cyc_b.size() >= 2) begin
      n_vec++;
      if (cyc_b[1] - cyc_b[0] < 100 || cyc_b[1] - cyc_b[0] > 105) begin
        n_miss++; $display("FAIL timeout_spacing: got %0d cycles want 100..105", cyc_b[1] - cyc_b[0]);
      end
    end
  endtask

  task automatic test_wl18();
    bit ok = 1'b0;
    rst_c = 1'b1;
    for (int k = 0; k < 2000; k++) begin
      @(posedge clk); #1;
      if (cdone_c) begin ok = 1'b1; break; end
    end
    n_vec++;
    if (!ok || log_c.size() != 9 || log_c[8] !== 16'h0E02 || log_c[0] !== 16'h1E00) begin
      n_miss++; $display("FAIL wl18_run: done=%0b writes=%0d last=%h want 1 9 0e02",
                         cdone_c, log_c.size(), (log_c.size() > 0) ? log_c[log_c.size()-1] : 16'h0);
    end
  endtask

  task automatic test_user_wr();
    int  acks = 0;
    bit  done_dropped = 1'b0;
    log_a.delete(); cyc_a.delete();
    @(posedge clk); #1;
    ureq_a = 1'b1; uaddr_a = 7'h02; udata_a = 9'h1F0;
    for (int k = 0; k < 300; k++) begin
      @(posedge clk); #1;
      if (!cdone_a) done_dropped = 1'b1;
      if (uack_a) begin acks++; ureq_a = 1'b0; end
    end
    ureq_a = 1'b0;
`ifdef CODEC_CFG_USER_WR_EN
    n_vec++;
    if (acks != 1) begin n_miss++; $display("FAIL user_ack_pulses: got %0d want 1", acks); end
    n_vec++;
    if (log_a.size() != 1 || addr_a !== 8'h05 || dw_a !== 8'hF0) begin
      n_miss++; $display("FAIL user_write_bus: writes=%0d addr=%h data=%h want 1 05 f0", log_a.size(), addr_a, dw_a);
    end
    n_vec++;
    if (done_dropped || cdone_a !== 1'b1 || busy_a !== 1'b0) begin
      n_miss++; $display("FAIL user_done_kept: dropped=%0b done=%0b busy=%0b want 0 1 0", done_dropped, cdone_a, busy_a);
    end
    // instance B sits in ERROR with a silent driver: user write must fail with index 31
    log_b.delete();
    ureq_b = 1'b1; uaddr_b = 7'h04; udata_b = 9'h010;
    for (int k = 0; k < 1000; k++) begin
      @(posedge clk); #1;
      if (log_b.size() >= 1) ureq_b = 1'b0;
      if (log_b.size() >= 4 && !busy_b) break;
    end
    ureq_b = 1'b0;
    n_vec++;
    if (eidx_b !== 5'd31 || err_b !== 1'b1 || log_b.size() != 4) begin
      n_miss++; $display("FAIL user_fail: eidx=%0d err=%0b writes=%0d want 31 1 4", eidx_b, err_b, log_b.size());
    end
`else
    n_vec++;
    if (acks != 0 || log_a.size() != 0 || done_dropped) begin
      n_miss++; $display("FAIL user_ignored: acks=%0d writes=%0d dropped=%0b want 0 0 0", acks, log_a.size(), done_dropped);
    end
`endif
  endtask

  initial begin
    test_reset();
    test_full_run();
    test_nack_retry();
    test_nack_fail();
    test_restart();
    test_reset_mid();
    test_wl24_timeout();
    test_wl18();
    test_user_wr();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
